// File: rtl/p_seq.sv
// MERA-400 execution-phase sequencer: state flags, strobes, loop counter,
// memory-wait supervision for the P-D decoder.
module p_seq #(
  parameter int MEM_TIMEOUT = 16,
  parameter int LK_BITS     = 4
) (
  input  logic               clk_sys,
  input  logic               rst,
  input  logic               start,
  input  logic               nef,
  input  logic               ewa,
  input  logic               ewp,
  input  logic               ewe,
  input  logic               ewr,
  input  logic               eww,
  input  logic               ewm,
  input  logic               ewx,
  input  logic               ewz,
  input  logic               ew__,
  input  logic               ekc_1,
  input  logic               ekc_2,
  input  logic               mem_ok,
  input  logic               lk_load,
  input  logic [LK_BITS-1:0] lk_val,
  output logic               pp,
  output logic               wr,
  output logic               ww,
  output logic               wa,
  output logic               wx,
  output logic               wz,
  output logic               wm,
  output logic               we,
  output logic               wp,
  output logic               w__,
  output logic               strob1,
  output logic               strob2,
  output logic               got,
  output logic               lk,
  output logic               kc,
  output logic               busy,
  output logic               alarm_nomem,
  output logic               seq_err
);

  localparam int TW =
    (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

  typedef enum logic [3:0] {
    S_IDLE, S_PP, S_WR, S_WW, S_WA, S_WX,
    S_WZ, S_WM, S_WE, S_WP, S_WAMP
  } state_e;

  typedef enum logic [1:0] {
    PH_ST1, PH_WAIT, PH_ST2, PH_GOT
  } phase_e;

  state_e               state_q;
  phase_e               phase_q;
  logic [TW-1:0]        tmr_q;
  logic [LK_BITS-1:0]   cnt_q;
  logic [LK_BITS-1:0]   cnt_d;
  logic                 kc_q;
  logic                 err_q;
  logic                 alarm_q;

  state_e               req_st;
  logic                 req_any;
  logic                 mem_st;
  logic                 tmr_last;
  logic                 end_req;

  assign mem_st   = (state_q == S_WR) ||
                    (state_q == S_WW);
  assign tmr_last = tmr_q == TW'(MEM_TIMEOUT - 1);
  assign end_req  = ekc_1 || ekc_2 ||
                    (state_q == S_PP && nef);

  // Fixed request priority; lower requests are dropped
  always_comb begin
    req_any = 1'b1;
    req_st  = S_IDLE;
    if (ew__)     req_st = S_WAMP;
    else if (ewe) req_st = S_WE;
    else if (ewa) req_st = S_WA;
    else if (ewp) req_st = S_WP;
    else if (ewr) req_st = S_WR;
    else if (eww) req_st = S_WW;
    else if (ewm) req_st = S_WM;
    else if (ewx) req_st = S_WX;
    else if (ewz) req_st = S_WZ;
    else          req_any = 1'b0;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (lk_load)
      cnt_d = lk_val;
    else if (state_q == S_WX &&
             phase_q == PH_GOT &&
             cnt_q != '0)
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= S_IDLE;
      phase_q <= PH_ST1;
      tmr_q   <= '0;
      cnt_q   <= '0;
      kc_q    <= 1'b0;
      err_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      kc_q  <= 1'b0;
      err_q <= 1'b0;
      if (state_q == S_IDLE) begin
        phase_q <= PH_ST1;
        tmr_q   <= '0;
        if (start) begin
          state_q <= S_PP;
          alarm_q <= 1'b0;
        end
      end else begin
        unique case (phase_q)
          PH_ST1, PH_WAIT: begin
            if (!mem_st || mem_ok) begin
              phase_q <= PH_ST2;
              tmr_q   <= '0;
            end else if (tmr_last) begin
              alarm_q <= 1'b1;
              kc_q    <= 1'b1;
              state_q <= S_IDLE;
              phase_q <= PH_ST1;
              tmr_q   <= '0;
            end else begin
              phase_q <= PH_WAIT;
              tmr_q   <= tmr_q + 1'b1;
            end
          end
          PH_ST2: phase_q <= PH_GOT;
          PH_GOT: begin
            phase_q <= PH_ST1;
            if (end_req) begin
              kc_q    <= 1'b1;
              state_q <= S_IDLE;
            end else if (req_any) begin
              state_q <= req_st;
            end else begin
              kc_q    <= 1'b1;
              err_q   <= 1'b1;
              state_q <= S_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign pp  = state_q == S_PP;
  assign wr  = state_q == S_WR;
  assign ww  = state_q == S_WW;
  assign wa  = state_q == S_WA;
  assign wx  = state_q == S_WX;
  assign wz  = state_q == S_WZ;
  assign wm  = state_q == S_WM;
  assign we  = state_q == S_WE;
  assign wp  = state_q == S_WP;
  assign w__ = state_q == S_WAMP;

  assign busy   = state_q != S_IDLE;
  assign strob1 = busy && phase_q == PH_ST1;
  assign strob2 = busy && phase_q == PH_ST2;
  assign got    = busy && phase_q == PH_GOT;

  assign lk          = cnt_q == '0;
  assign kc          = kc_q;
  assign seq_err     = err_q;
  assign alarm_nomem = alarm_q;

endmodule

// File: tb/tb_p_seq.sv
// Randomised bench for p_seq against a visit-level sequencer model.
module tb_p_seq;

  logic clk_sys = 1'b0;
  logic rst, start, nef;
  logic ewa, ewp, ewe, ewr, eww;
  logic ewm, ewx, ewz, ew__;
  logic ekc_1, ekc_2, mem_ok, lk_load;
  logic [3:0] lk_val;
  logic pp, wr, ww, wa, wx, wz, wm, we, wp, w__;
  logic strob1, strob2, got, lk, kc;
  logic busy, alarm_nomem, seq_err;

  always #5 clk_sys = ~clk_sys;

  p_seq #(.MEM_TIMEOUT(16), .LK_BITS(4)) dut (
    .clk_sys(clk_sys), .rst(rst), .start(start),
    .nef(nef), .ewa(ewa), .ewp(ewp), .ewe(ewe),
    .ewr(ewr), .eww(eww), .ewm(ewm), .ewx(ewx),
    .ewz(ewz), .ew__(ew__), .ekc_1(ekc_1),
    .ekc_2(ekc_2), .mem_ok(mem_ok),
    .lk_load(lk_load), .lk_val(lk_val),
    .pp(pp), .wr(wr), .ww(ww), .wa(wa), .wx(wx),
    .wz(wz), .wm(wm), .we(we), .wp(wp), .w__(w__),
    .strob1(strob1), .strob2(strob2), .got(got),
    .lk(lk), .kc(kc), .busy(busy),
    .alarm_nomem(alarm_nomem), .seq_err(seq_err)
  );

  // State ids: 0 idle,1 PP,2 WR,3 WW,4 WA,5 WX,6 WZ,7 WM,8 WE,9 WP,10 W&
  // Request bit b (8=ew__ .. 0=ewz) in priority order -> target state
  int tbl [9] = '{6, 5, 7, 3, 2, 9, 4, 8, 10};

  int n_chk  = 0;
  int n_pass = 0;
  int cur_s, mcnt, nvis, wx_obs;
  logic [2:0] exp_strb;
  logic exp_kc, exp_err, exp_alarm;
  bit rnd_lk, lk_mode;
  logic [11:0] q_got[$];
  int q_wait[$];

  task automatic chk(input string tag,
                     input int obs, input int exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  tag, obs, exp);
  endtask

  function automatic logic [9:0] fl(input int s);
    return (s == 0) ? 10'd0 : 10'(1 << (10 - s));
  endfunction

  task automatic apply(input logic [11:0] v);
    {nef, ekc_1, ekc_2, ew__, ewe, ewa, ewp,
     ewr, eww, ewm, ewx, ewz} = v;
  endtask

  task automatic noise();
    apply(12'($urandom));
    start   = ($urandom % 3) == 0;
    lk_load = rnd_lk && (($urandom % 10) == 0);
    lk_val  = 4'($urandom);
    mem_ok  = 1'($urandom);
    rst     = 1'b0;
  endtask

  task automatic tick();
    chk("flags",
        int'({pp, wr, ww, wa, wx, wz, wm, we, wp, w__}),
        int'(fl(cur_s)));
    chk("strobes", int'({strob1, strob2, got}),
        int'(exp_strb));
    chk("kc", int'(kc), int'(exp_kc));
    chk("seq_err", int'(seq_err), int'(exp_err));
    chk("busy", int'(busy), int'(cur_s != 0));
    chk("alarm", int'(alarm_nomem), int'(exp_alarm));
    chk("lk", int'(lk), int'(mcnt == 0));
    if (wx && got) wx_obs++;
    if (rst) mcnt = 0;
    else if (lk_load) mcnt = int'(lk_val);
    else if (cur_s == 5 && exp_strb == 3'b001 &&
             mcnt > 0) mcnt--;
    exp_kc  = 1'b0;
    exp_err = 1'b0;
    if (rst) exp_alarm = 1'b0;
    @(negedge clk_sys);
  endtask

  task automatic idle_cycle(input bit st, input bit ld,
                            input logic [3:0] val);
    noise();
    start = st;
    if (ld) begin
      lk_load = 1'b1;
      lk_val  = val;
    end
    cur_s    = 0;
    exp_strb = 3'b000;
    tick();
    if (st) exp_alarm = 1'b0;
  endtask

  function automatic logic [11:0] pick_got(input int s);
    int r;
    if (lk_mode && s == 5)
      return (mcnt == 0) ? 12'h400 : 12'h002;
    if (q_got.size() > 0) return q_got.pop_front();
    if (nvis > 20) return 12'h400;
    r = int'($urandom % 8);
    if (r == 0) return 12'h000;
    if (r <= 2)
      return {1'b0, 2'($urandom % 3 + 1), 9'($urandom)};
    return {1'(($urandom % 4) == 0), 2'b00,
            9'($urandom)};
  endfunction

  task automatic do_state(input int s, output int nxt);
    int w;
    bit mem;
    logic [11:0] v;
    mem = (s == 2 || s == 3);
    w = 0;
    if (mem) begin
      if (q_wait.size() > 0) w = q_wait.pop_front();
      else if (($urandom % 6) == 0) w = 99;
      else w = int'($urandom % 5);
    end
    cur_s = s;
    nvis++;
    exp_strb = 3'b100;
    noise();
    if (mem) mem_ok = (w == 0);
    tick();
    if (mem)
      for (int k = 1; k <= w && k < 16; k++) begin
        exp_strb = 3'b000;
        noise();
        mem_ok = (k == w);
        tick();
      end
    nxt = 0;
    if (mem && w >= 16) begin
      exp_kc    = 1'b1;
      exp_alarm = 1'b1;
      return;
    end
    exp_strb = 3'b010;
    noise();
    tick();
    exp_strb = 3'b001;
    noise();
    v = pick_got(s);
    apply(v);
    tick();
    if ((s == 1 && v[11]) || v[10] || v[9]) begin
      exp_kc = 1'b1;
    end else begin
      for (int b = 8; b >= 0; b--)
        if (v[b]) begin
          nxt = tbl[b];
          break;
        end
      if (nxt == 0) begin
        exp_kc  = 1'b1;
        exp_err = 1'b1;
      end
    end
  endtask

  task automatic instr();
    int s, nxt;
    s = 1;
    nvis = 0;
    forever begin
      do_state(s, nxt);
      if (nxt == 0) break;
      s = nxt;
    end
  endtask

  initial begin
    int nxt;
    rst = 1'b1;
    apply(12'h000);
    start = 1'b1;
    mem_ok = 1'b0;
    lk_load = 1'b0;
    lk_val = 4'd0;
    rnd_lk = 1'b0;
    lk_mode = 1'b0;
    mcnt = 0;
    wx_obs = 0;
    exp_kc = 1'b0;
    exp_err = 1'b0;
    exp_alarm = 1'b0;
    @(negedge clk_sys);
    @(negedge clk_sys);
    idle_cycle(0, 0, 4'd0);
    idle_cycle(0, 0, 4'd0);

    // nef at PP GOT overrides requests
    q_got.push_back(12'h810);
    idle_cycle(1, 0, 4'd0);
    instr();
    idle_cycle(0, 0, 4'd0);

    // WR with two wait cycles, then ekc_2
    q_got.push_back(12'h010);
    q_got.push_back(12'h200);
    q_wait.push_back(2);
    idle_cycle(1, 0, 4'd0);
    instr();
    idle_cycle(0, 0, 4'd0);

    // ewa+ewe picks WE; empty GOT gives seq_err
    q_got.push_back(12'h0C0);
    q_got.push_back(12'h000);
    idle_cycle(1, 0, 4'd0);
    instr();
    idle_cycle(0, 0, 4'd0);

    // loop counter: 3 loaded gives 4 WX passes
    q_got.push_back(12'h002);
    lk_mode = 1'b1;
    idle_cycle(1, 1, 4'd3);
    wx_obs = 0;
    instr();
    chk("wx_passes", wx_obs, 4);
    lk_mode = 1'b0;
    idle_cycle(0, 0, 4'd0);

    // memory timeout, then back-to-back start clears alarm
    q_got.push_back(12'h010);
    q_wait.push_back(99);
    idle_cycle(1, 0, 4'd0);
    instr();
    idle_cycle(0, 0, 4'd0);
    q_got.push_back(12'h020);
    q_got.push_back(12'h400);
    idle_cycle(1, 0, 4'd0);
    instr();
    q_got.push_back(12'h400);
    idle_cycle(1, 0, 4'd0);
    instr();
    idle_cycle(0, 0, 4'd0);

    // reset during WW ST2, with start held
    idle_cycle(0, 1, 4'd9);
    q_got.push_back(12'h008);
    idle_cycle(1, 0, 4'd0);
    nvis = 0;
    do_state(1, nxt);
    cur_s = nxt;
    exp_strb = 3'b100;
    noise();
    mem_ok = 1'b1;
    tick();
    exp_strb = 3'b010;
    noise();
    rst = 1'b1;
    start = 1'b1;
    tick();
    idle_cycle(0, 0, 4'd0);
    idle_cycle(0, 0, 4'd0);

    rnd_lk = 1'b1;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom % 3) idle_cycle(0, 0, 4'd0);
      idle_cycle(1, 0, 4'd0);
      instr();
    end
    idle_cycle(0, 0, 4'd0);
    idle_cycle(0, 0, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
